// File: rtl/axi_read_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-style read slave port among MASTER_NUM masters.
// One transaction (AR handshake through R handshake) is owned by a single master at a time;
// priority rotates starting just after the most recently completed master.
module axi_read_rr_arbiter #(
   parameter int unsigned MASTER_NUM = 3,
   parameter int unsigned ADDR_LEN   = 32,
   parameter int unsigned DATA_LEN   = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [MASTER_NUM-1:0]            m_arvalid_i,
   output logic [MASTER_NUM-1:0]            m_arready_o,
   input  logic [MASTER_NUM*ADDR_LEN-1:0]   m_raddr_i,
   output logic [MASTER_NUM-1:0]            m_rvalid_o,
   input  logic [MASTER_NUM-1:0]            m_rready_i,
   output logic [2:0]                       m_rresp_o,
   output logic [DATA_LEN-1:0]              m_rdata_o,
   output logic                             s_arvalid_o,
   input  logic                             s_arready_i,
   output logic [ADDR_LEN-1:0]              s_raddr_o,
   input  logic                             s_rvalid_i,
   output logic                             s_rready_o,
   input  logic [2:0]                       s_rresp_i,
   input  logic [DATA_LEN-1:0]              s_rdata_i,
   output logic [MASTER_NUM-1:0]            grant_o
);

   localparam int unsigned IdxW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StAddr = 2'd1;
   localparam logic [1:0] StData = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [MASTER_NUM-1:0] grant_q, grant_d;
   logic [IdxW-1:0]       last_q, last_d;

   logic [IdxW-1:0]       g_idx;
   logic [IdxW-1:0]       pick_idx;
   logic                  pick_found;
   int unsigned           cand;

   // Binary index of the current owner, decoded from the one-hot grant.
   always_comb begin
      g_idx = '0;
      for (int i = 0; i < int'(MASTER_NUM); i++) begin
         if (grant_q[i]) g_idx = IdxW'(i);
      end
   end

   // Rotating-priority search starting at last+1, wrapping modulo MASTER_NUM.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int unsigned off = 1; off <= MASTER_NUM; off++) begin
         cand = (32'(last_q) + off) % MASTER_NUM;
         if (!pick_found && m_arvalid_i[cand]) begin
            pick_found = 1'b1;
            pick_idx   = IdxW'(cand);
         end
      end
   end

   // Channel steering: only the granted master is connected, and only in its phase.
   always_comb begin
      m_arready_o = '0;
      m_rvalid_o  = '0;
      s_arvalid_o = 1'b0;
      s_rready_o  = 1'b0;
      s_raddr_o   = m_raddr_i[ADDR_LEN-1:0];
      m_rdata_o   = s_rdata_i;
      m_rresp_o   = s_rresp_i;
      if (state_q == StAddr) begin
         s_arvalid_o        = m_arvalid_i[g_idx];
         s_raddr_o          = m_raddr_i[32'(g_idx)*ADDR_LEN +: ADDR_LEN];
         m_arready_o[g_idx] = s_arready_i;
      end else if (state_q == StData) begin
         m_rvalid_o[g_idx] = s_rvalid_i;
         s_rready_o        = m_rready_i[g_idx];
      end
   end

   // Next-state logic for the IDLE -> ADDR -> DATA transaction sequence.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         StIdle: begin
            grant_d = '0;
            if (pick_found) begin
               grant_d[pick_idx] = 1'b1;
               state_d           = StAddr;
            end
         end
         StAddr: begin
            // A master dropping arvalid here just stalls; no re-arbitration.
            if (s_arvalid_o && s_arready_i) state_d = StData;
         end
         StData: begin
            if (s_rvalid_i && s_rready_o) begin
               last_d  = g_idx;
               grant_d = '0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
   end

   // State registers; last resets to MASTER_NUM-1 so master 0 wins first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         grant_q <= '0;
         last_q  <= IdxW'(MASTER_NUM - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign grant_o = grant_q;

endmodule

// File: tb/tb_axi_read_rr_arbiter.sv
// Directed bench for axi_read_rr_arbiter: a cycle table plus hand-written corner sequences.
module tb_axi_read_rr_arbiter;

   localparam int unsigned MN = 3;
   localparam int unsigned AL = 32;
   localparam int unsigned DL = 32;

   localparam logic [31:0] A0 = 32'h1000_0000;
   localparam logic [31:0] A1 = 32'h8000_0010;
   localparam logic [31:0] A2 = 32'h2000_0020;

   logic              clk;
   logic              rst_n;
   logic [MN-1:0]     m_arvalid;
   logic [MN-1:0]     m_arready;
   logic [MN*AL-1:0]  m_raddr;
   logic [MN-1:0]     m_rvalid;
   logic [MN-1:0]     m_rready;
   logic [2:0]        m_rresp;
   logic [DL-1:0]     m_rdata;
   logic              s_arvalid;
   logic              s_arready;
   logic [AL-1:0]     s_raddr;
   logic              s_rvalid;
   logic              s_rready;
   logic [2:0]        s_rresp;
   logic [DL-1:0]     s_rdata;
   logic [MN-1:0]     grant;

   int tests_run;
   int tests_failed;

   axi_read_rr_arbiter #(
      .MASTER_NUM(MN),
      .ADDR_LEN  (AL),
      .DATA_LEN  (DL)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .m_arvalid_i(m_arvalid),
      .m_arready_o(m_arready),
      .m_raddr_i  (m_raddr),
      .m_rvalid_o (m_rvalid),
      .m_rready_i (m_rready),
      .m_rresp_o  (m_rresp),
      .m_rdata_o  (m_rdata),
      .s_arvalid_o(s_arvalid),
      .s_arready_i(s_arready),
      .s_raddr_o  (s_raddr),
      .s_rvalid_i (s_rvalid),
      .s_rready_o (s_rready),
      .s_rresp_i  (s_rresp),
      .s_rdata_i  (s_rdata),
      .grant_o    (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  arv;
      logic [2:0]  rr;
      logic        sar;
      logic        srv;
      logic [31:0] rdata;
      logic [2:0]  g;
      logic [2:0]  arr;
      logic [2:0]  rv;
      logic        sarv;
      logic        srr;
      logic [31:0] raddr;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input logic [2:0] arv, input logic srv, input logic [31:0] rdata,
                               input logic [2:0] g, input logic [2:0] arr, input logic [2:0] rv,
                               input logic sarv, input logic srr, input logic [31:0] raddr);
      vec_t v;
      v.arv = arv; v.rr = 3'b111; v.sar = 1'b1; v.srv = srv; v.rdata = rdata;
      v.g = g; v.arr = arr; v.rv = rv; v.sarv = sarv; v.srr = srr; v.raddr = raddr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      m_arvalid = '0;
      m_rready  = '1;
      s_arready = 1'b1;
      s_rvalid  = 1'b0;
      s_rdata   = '0;
      s_rresp   = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called at a negedge: settle combinational outputs, then advance one full cycle.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      logic [2:0] exp_g[12];
      tests_run    = 0;
      tests_failed = 0;
      m_raddr      = {A2, A1, A0};

      // Single request from master 1, then masters 0 and 2 together with last = 1.
      tbl[0]  = mk(3'b010, 1'b0, 32'h0,         3'b000, 3'b000, 3'b000, 1'b0, 1'b0, A0);
      tbl[1]  = mk(3'b010, 1'b0, 32'h0,         3'b010, 3'b010, 3'b000, 1'b1, 1'b0, A1);
      tbl[2]  = mk(3'b000, 1'b0, 32'h0,         3'b010, 3'b000, 3'b000, 1'b0, 1'b1, A0);
      tbl[3]  = mk(3'b000, 1'b1, 32'hDEAD_BEEF, 3'b010, 3'b000, 3'b010, 1'b0, 1'b1, A0);
      tbl[4]  = mk(3'b000, 1'b0, 32'h0,         3'b000, 3'b000, 3'b000, 1'b0, 1'b0, A0);
      tbl[5]  = mk(3'b101, 1'b0, 32'h0,         3'b000, 3'b000, 3'b000, 1'b0, 1'b0, A0);
      tbl[6]  = mk(3'b101, 1'b0, 32'h0,         3'b100, 3'b100, 3'b000, 1'b1, 1'b0, A2);
      tbl[7]  = mk(3'b001, 1'b1, 32'hCAFE_F00D, 3'b100, 3'b000, 3'b100, 1'b0, 1'b1, A0);
      tbl[8]  = mk(3'b001, 1'b0, 32'h0,         3'b000, 3'b000, 3'b000, 1'b0, 1'b0, A0);
      tbl[9]  = mk(3'b001, 1'b0, 32'h0,         3'b001, 3'b001, 3'b000, 1'b1, 1'b0, A0);
      tbl[10] = mk(3'b000, 1'b1, 32'h1234_5678, 3'b001, 3'b000, 3'b001, 1'b0, 1'b1, A0);
      tbl[11] = mk(3'b000, 1'b0, 32'h0,         3'b000, 3'b000, 3'b000, 1'b0, 1'b0, A0);

      // Reset state, checked while rst_n is still low.
      rst_n = 1'b0;
      m_arvalid = '0; m_rready = '1; s_arready = 1'b1; s_rvalid = 1'b0;
      s_rdata = '0; s_rresp = '0;
      #3;
      chk("reset grant", 64'(grant), 64'h0);
      chk("reset m_arready", 64'(m_arready), 64'h0);
      chk("reset m_rvalid", 64'(m_rvalid), 64'h0);
      chk("reset s_arvalid", 64'(s_arvalid), 64'h0);
      chk("reset s_rready", 64'(s_rready), 64'h0);
      do_reset();

      for (int i = 0; i < 12; i++) begin
         m_arvalid = tbl[i].arv;
         m_rready  = tbl[i].rr;
         s_arready = tbl[i].sar;
         s_rvalid  = tbl[i].srv;
         s_rdata   = tbl[i].rdata;
         s_rresp   = 3'(i);
         #1;
         chk($sformatf("vec%0d grant", i), 64'(grant), 64'(tbl[i].g));
         chk($sformatf("vec%0d m_arready", i), 64'(m_arready), 64'(tbl[i].arr));
         chk($sformatf("vec%0d m_rvalid", i), 64'(m_rvalid), 64'(tbl[i].rv));
         chk($sformatf("vec%0d s_arvalid", i), 64'(s_arvalid), 64'(tbl[i].sarv));
         chk($sformatf("vec%0d s_rready", i), 64'(s_rready), 64'(tbl[i].srr));
         chk($sformatf("vec%0d s_raddr", i), 64'(s_raddr), 64'(tbl[i].raddr));
         chk($sformatf("vec%0d m_rdata", i), 64'(m_rdata), 64'(tbl[i].rdata));
         chk($sformatf("vec%0d m_rresp", i), 64'(m_rresp), 64'(i % 8));
         next_cycle();
      end

      // All three request continuously: order 0,1,2,0 with one idle cycle between grants.
      do_reset();
      exp_g = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                3'b000, 3'b100, 3'b100, 3'b000, 3'b001, 3'b001};
      m_arvalid = 3'b111; s_arready = 1'b1; s_rvalid = 1'b1; m_rready = 3'b111;
      for (int c = 0; c < 12; c++) begin
         #1;
         chk($sformatf("rr cycle%0d grant", c), 64'(grant), 64'(exp_g[c]));
         next_cycle();
      end

      // s_arready held low 5 cycles in ADDR, then m_rready low 3 cycles in DATA.
      do_reset();
      m_arvalid = 3'b010; s_arready = 1'b0; s_rvalid = 1'b0; m_rready = 3'b111;
      next_cycle();
      for (int c = 1; c <= 5; c++) begin
         #1;
         chk($sformatf("arstall%0d s_arvalid", c), 64'(s_arvalid), 64'h1);
         chk($sformatf("arstall%0d s_raddr", c), 64'(s_raddr), 64'(A1));
         chk($sformatf("arstall%0d m_arready", c), 64'(m_arready), 64'h0);
         next_cycle();
      end
      s_arready = 1'b1;
      #1;
      chk("arstall c6 m_arready", 64'(m_arready), 64'(3'b010));
      next_cycle();
      m_arvalid = 3'b000; s_rvalid = 1'b1; m_rready = 3'b000;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("rstall%0d s_rready", c), 64'(s_rready), 64'h0);
         chk($sformatf("rstall%0d grant", c), 64'(grant), 64'(3'b010));
         chk($sformatf("rstall%0d m_rvalid", c), 64'(m_rvalid), 64'(3'b010));
         next_cycle();
      end
      m_rready = 3'b010;
      #1;
      chk("rstall release s_rready", 64'(s_rready), 64'h1);
      next_cycle();
      s_rvalid = 1'b0;
      #1;
      chk("rstall done grant", 64'(grant), 64'h0);

      // Reset during DATA after master 0 completed: priority must restart at master 0.
      do_reset();
      m_arvalid = 3'b001; s_arready = 1'b1; s_rvalid = 1'b1; m_rready = 3'b111;
      next_cycle();
      next_cycle();
      next_cycle();
      m_arvalid = 3'b010; s_rvalid = 1'b0;
      next_cycle();
      next_cycle();
      #1;
      chk("mid-data grant", 64'(grant), 64'(3'b010));
      chk("mid-data s_rready", 64'(s_rready), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("async rst grant", 64'(grant), 64'h0);
      chk("async rst s_rready", 64'(s_rready), 64'h0);
      chk("async rst s_arvalid", 64'(s_arvalid), 64'h0);
      chk("async rst m_arready", 64'(m_arready), 64'h0);
      chk("async rst m_rvalid", 64'(m_rvalid), 64'h0);
      next_cycle();
      rst_n = 1'b1;
      m_arvalid = 3'b111;
      next_cycle();
      #1;
      chk("post-reset grant", 64'(grant), 64'(3'b001));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
